// File: rtl/fetch_unit.sv
// Two-state fetch/execute sequencer over a small program memory; FETCH_INSTR_COUNT_EN adds a retired-instruction counter.
// Latency: 1 FETCH cycle then >=1 EXEC cycle, so one instruction per 2 cycles when unstalled.
// Backpressure: stall freezes EXEC (pc, IR, instr_valid held); next_pc is consumed only when EXEC completes.
module fetch_unit #(
  parameter int IMEM_AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        stall,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [7:0]  next_pc,
  output logic [7:0]  instruction,
  output logic [7:0]  current_pc,
  output logic        instr_valid,
  output logic        busy,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t     state, state_nxt;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [7:0] mem [0:(1<<IMEM_AW)-1];
  logic       pc_clr, pc_ld, ir_ld;
  logic       prog_in_range, fetch_in_range, prog_wr;
  logic [7:0] fetch_dat;

  // Addresses beyond the memory depth never alias: writes drop, fetches return NOP.
  assign prog_in_range  = (prog_addr >> IMEM_AW) == 8'h00;
  assign fetch_in_range = (pc >> IMEM_AW) == 8'h00;
  assign fetch_dat      = fetch_in_range ? mem[pc[IMEM_AW-1:0]] : 8'h00;
  assign prog_wr        = prog_we && prog_in_range && (state == IDLE || state == HALT);

  always_comb begin
    state_nxt = state;
    pc_clr    = 1'b0;
    pc_ld     = 1'b0;
    ir_ld     = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (run) begin
          pc_clr    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        ir_ld     = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        if (!stall) begin
          if (ir == 8'hFF) begin
            state_nxt = HALT;
          end else begin
            pc_ld     = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= 8'h00;
      ir    <= 8'h00;
    end else begin
      state <= state_nxt;
      if (pc_clr)
        pc <= 8'h00;
      else if (pc_ld)
        pc <= next_pc;
      if (ir_ld)
        ir <= fetch_dat;
    end
  end

  // Program memory survives reset so a reset-and-rerun replays the same program.
  always_ff @(posedge clk) begin
    if (prog_wr)
      mem[prog_addr[IMEM_AW-1:0]] <= prog_data;
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] cnt_q;
  logic        retire;
  logic        cnt_clr;

  assign retire  = (state == EXEC) && !stall;
  assign cnt_clr = (state == HALT) && run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= 16'h0000;
    else if (cnt_clr)
      cnt_q <= 16'h0000;
    else if (retire)
      cnt_q <= cnt_q + 16'd1;
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = 16'h0000;
`endif

  assign instruction = ir;
  assign current_pc  = pc;
  assign instr_valid = (state == EXEC);
  assign busy        = (state == FETCH) || (state == EXEC);
  assign halted      = (state == HALT);

endmodule
